// File: rtl/mem_rr_arbiter_if.sv
// Request/response bundle between two requesters, the round-robin arbiter and the memory.
// The arbiter uses the master modport; the surrounding environment uses the slave modport.
interface mem_rr_arbiter_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  r0_valid_i;
    logic                  r0_wr_rd_i;
    logic [ADDR_WIDTH-1:0] r0_addr_i;
    logic [WIDTH-1:0]      r0_wdata_i;
    logic                  r0_ready_o;
    logic [WIDTH-1:0]      r0_rdata_o;
    logic                  r0_err_o;

    logic                  r1_valid_i;
    logic                  r1_wr_rd_i;
    logic [ADDR_WIDTH-1:0] r1_addr_i;
    logic [WIDTH-1:0]      r1_wdata_i;
    logic                  r1_ready_o;
    logic [WIDTH-1:0]      r1_rdata_o;
    logic                  r1_err_o;

    logic                  mem_valid_o;
    logic                  mem_wr_rd_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WIDTH-1:0]      mem_wdata_o;
    logic                  mem_ready_i;
    logic [WIDTH-1:0]      mem_rdata_i;

    logic                  busy_o;
    logic                  grant_o;

    modport master (
        input  r0_valid_i, r0_wr_rd_i, r0_addr_i, r0_wdata_i,
        output r0_ready_o, r0_rdata_o, r0_err_o,
        input  r1_valid_i, r1_wr_rd_i, r1_addr_i, r1_wdata_i,
        output r1_ready_o, r1_rdata_o, r1_err_o,
        output mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
        input  mem_ready_i, mem_rdata_i,
        output busy_o, grant_o
    );

    modport slave (
        output r0_valid_i, r0_wr_rd_i, r0_addr_i, r0_wdata_i,
        input  r0_ready_o, r0_rdata_o, r0_err_o,
        output r1_valid_i, r1_wr_rd_i, r1_addr_i, r1_wdata_i,
        input  r1_ready_o, r1_rdata_o, r1_err_o,
        input  mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o,
        output mem_ready_i, mem_rdata_i,
        input  busy_o, grant_o
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port valid/ready memory.
// One command is latched, issued for one cycle, awaited (with timeout) and answered with a ready pulse.
module mem_rr_arbiter #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int TIMEOUT    = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    mem_rr_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                  wr_rd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      wdata;
    } cmd_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    cmd_t             req_cmd [2];
    logic [1:0]       req_valid;
    logic             sel;
    logic [7:0]       cnt_q, cnt_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             mem_valid_q, mem_valid_d;
    logic             busy_q, busy_d;
    logic [1:0]       ready_q, ready_d;
    logic [1:0]       err_q, err_d;
    logic [WIDTH-1:0] rdata_q [2];
    logic [WIDTH-1:0] rdata_d [2];

    assign req_valid  = {bus.r1_valid_i, bus.r0_valid_i};
    assign req_cmd[0] = {bus.r0_wr_rd_i, bus.r0_addr_i, bus.r0_wdata_i};
    assign req_cmd[1] = {bus.r1_wr_rd_i, bus.r1_addr_i, bus.r1_wdata_i};

    // On a tie the requester that did not win last time is served.
    assign sel = (&req_valid) ? ~last_q : req_valid[1];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case infers a latch.
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        ready_d = '0;
        err_d   = '0;
        rdata_d = rdata_q;

        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = sel;
                    last_d  = sel;
                    cmd_d   = req_cmd[sel];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_ready_i) begin
                    if (!cmd_q.wr_rd) rdata_d[grant_q] = bus.mem_rdata_i;
                    ready_d[grant_q] = 1'b1;
                    state_d          = RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d            = cnt_q + 8'd1;
                    ready_d[grant_q] = 1'b1;
                    err_d[grant_q]   = 1'b1;
                    state_d          = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                // No arbitration here: a requester still holding valid waits for IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        mem_valid_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_q       <= '0;
            cnt_q       <= '0;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= '0;
            err_q       <= '0;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
        end else begin
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            mem_valid_q <= mem_valid_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            rdata_q[0]  <= rdata_d[0];
            rdata_q[1]  <= rdata_d[1];
        end
    end

    assign bus.mem_valid_o = mem_valid_q;
    assign bus.mem_wr_rd_o = cmd_q.wr_rd;
    assign bus.mem_addr_o  = cmd_q.addr;
    assign bus.mem_wdata_o = cmd_q.wdata;
    assign bus.busy_o      = busy_q;
    assign bus.grant_o     = grant_q;
    assign bus.r0_ready_o  = ready_q[0];
    assign bus.r1_ready_o  = ready_q[1];
    assign bus.r0_err_o    = err_q[0];
    assign bus.r1_err_o    = err_q[1];
    assign bus.r0_rdata_o  = rdata_q[0];
    assign bus.r1_rdata_o  = rdata_q[1];

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed bench for mem_rr_arbiter with a behavioural one-cycle-latency memory.
module tb_mem_rr_arbiter;
    logic clk_i   = 1'b0;
    logic rst_n_i = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    bit   mem_en  = 1'b1;
    logic [7:0] mem [16] = '{default: 8'h00};

    mem_rr_arbiter_if #(.WIDTH(8), .ADDR_WIDTH(4)) bus ();

    mem_rr_arbiter #(.DEPTH(16), .WIDTH(8), .TIMEOUT(8)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    // Memory answers one cycle after a valid; mem_en=0 models a memory that never answers.
    always @(posedge clk_i) begin
        if (mem_en && bus.mem_valid_o) begin
            if (bus.mem_wr_rd_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
            bus.mem_rdata_i <= mem[bus.mem_addr_o];
            bus.mem_ready_i <= 1'b1;
        end else begin
            bus.mem_ready_i <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {28'd0, bus.mem_valid_o, bus.mem_wr_rd_o, bus.mem_addr_o, bus.mem_wdata_o,
                bus.busy_o, bus.grant_o, bus.r0_ready_o, bus.r0_err_o, bus.r1_ready_o,
                bus.r1_err_o, bus.r0_rdata_o, bus.r1_rdata_o};
    endfunction

    task automatic drive(input int n, input logic v, input logic wr, input logic [3:0] a,
                         input logic [7:0] d);
        if (n == 0) begin
            bus.r0_valid_i = v; bus.r0_wr_rd_i = wr; bus.r0_addr_i = a; bus.r0_wdata_i = d;
        end else begin
            bus.r1_valid_i = v; bus.r1_wr_rd_i = wr; bus.r1_addr_i = a; bus.r1_wdata_i = d;
        end
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? bus.r0_ready_o : bus.r1_ready_o;
    endfunction

    function automatic logic [7:0] rdat(input int n);
        return (n == 0) ? bus.r0_rdata_o : bus.r1_rdata_o;
    endfunction

    function automatic logic errf(input int n);
        return (n == 0) ? bus.r0_err_o : bus.r1_err_o;
    endfunction

    // Counts negedges until requester n sees ready; lat=-1 if the budget runs out.
    task automatic wait_ready(input int n, input int max_cyc, output int lat, output int mv_at,
                              output int mv_cnt);
        lat = -1; mv_at = -1; mv_cnt = 0;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk_i);
            if (bus.mem_valid_o) begin
                mv_cnt++;
                if (mv_at < 0) mv_at = k;
            end
            if (rdy(n)) begin
                lat = k;
                break;
            end
        end
    endtask

    // One complete transfer started from IDLE; returns at the following IDLE negedge.
    task automatic xfer(input string tag, input int n, input logic wr, input logic [3:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rdata, input int exp_lat,
                        input logic exp_err);
        int lat, mv_at, mv_cnt;
        drive(n, 1'b1, wr, a, d);
        wait_ready(n, 40, lat, mv_at, mv_cnt);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_mv_at"}, 64'(mv_at), 64'd1);
        check({tag, "_mv_cnt"}, 64'(mv_cnt), 64'd1);
        check({tag, "_err"}, 64'(errf(n)), 64'(exp_err));
        check({tag, "_rdata"}, 64'(rdat(n)), 64'(exp_rdata));
        check({tag, "_grant"}, 64'(bus.grant_o), 64'(n));
        drive(n, 1'b0, wr, a, d);
        @(negedge clk_i);
        check({tag, "_done"}, {62'd0, rdy(n), bus.busy_o}, 64'd0);
    endtask

    initial begin
        int lat, mv_at, mv_cnt, ev;
        int          ct_who  [4] = '{0, 1, 0, 1};
        int          ct_k    [4] = '{3, 7, 11, 15};
        logic [7:0]  ct_data [4] = '{8'hA5, 8'h22, 8'hA5, 8'h33};
        logic [7:0]  bb_data [3] = '{8'h11, 8'h22, 8'h33};
        int i0, i1;

        drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (3) @(negedge clk_i);
        check("reset_outs", all_outs(), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        check("post_reset_outs", all_outs(), 64'd0);

        // r0 write then read back
        xfer("t1w", 0, 1'b1, 4'd3, 8'hA5, 8'h00, 3, 1'b0);
        xfer("t1r", 0, 1'b0, 4'd3, 8'h00, 8'hA5, 3, 1'b0);

        // r1 pre-writes, then three back-to-back reads with valid held high
        xfer("t3w0", 1, 1'b1, 4'd0, 8'h11, 8'h00, 3, 1'b0);
        xfer("t3w1", 1, 1'b1, 4'd1, 8'h22, 8'h00, 3, 1'b0);
        xfer("t3w2", 1, 1'b1, 4'd2, 8'h33, 8'h00, 3, 1'b0);
        ev = 0;
        drive(1, 1'b1, 1'b0, 4'd0, 8'd0);
        for (int k = 1; k <= 40 && ev < 3; k++) begin
            @(negedge clk_i);
            check("t3_no_r0_ready", 64'(bus.r0_ready_o), 64'd0);
            if (bus.r1_ready_o) begin
                check("t3_cycle", 64'(k), 64'(4 * ev + 3));
                check("t3_rdata", 64'(bus.r1_rdata_o), 64'(bb_data[ev]));
                check("t3_grant", 64'(bus.grant_o), 64'd1);
                ev++;
                if (ev < 3) drive(1, 1'b1, 1'b0, 4'(ev), 8'd0);
                else drive(1, 1'b0, 1'b0, 4'd0, 8'd0);
            end
        end
        check("t3_events", 64'(ev), 64'd3);
        @(negedge clk_i);

        // both requesters contend continuously; last winner was r1
        ev = 0; i0 = 0; i1 = 0;
        drive(0, 1'b1, 1'b0, 4'd3, 8'd0);
        drive(1, 1'b1, 1'b0, 4'd1, 8'd0);
        for (int k = 1; k <= 40 && ev < 4; k++) begin
            @(negedge clk_i);
            check("t2_not_both", 64'(bus.r0_ready_o & bus.r1_ready_o), 64'd0);
            if (bus.r0_ready_o || bus.r1_ready_o) begin
                check("t2_who", 64'(bus.r1_ready_o), 64'(ct_who[ev]));
                check("t2_cycle", 64'(k), 64'(ct_k[ev]));
                check("t2_grant", 64'(bus.grant_o), 64'(ct_who[ev]));
                check("t2_rdata", 64'(bus.r1_ready_o ? bus.r1_rdata_o : bus.r0_rdata_o),
                      64'(ct_data[ev]));
                if (bus.r0_ready_o) begin
                    i0++;
                    if (i0 == 2) drive(0, 1'b0, 1'b0, 4'd3, 8'd0);
                end else begin
                    i1++;
                    drive(1, (i1 < 2), 1'b0, 4'd2, 8'd0);
                end
                ev++;
            end
        end
        check("t2_events", 64'(ev), 64'd4);
        @(negedge clk_i);

        // unresponsive memory: error after 8 WAIT cycles, rdata untouched, then normal service
        mem_en = 1'b0;
        xfer("t4to", 0, 1'b0, 4'd0, 8'd0, 8'hA5, 10, 1'b1);
        mem_en = 1'b1;
        xfer("t4ok", 0, 1'b0, 4'd0, 8'd0, 8'h11, 3, 1'b0);

        // asynchronous reset during WAIT
        mem_en = 1'b0;
        drive(0, 1'b1, 1'b0, 4'd3, 8'd0);
        repeat (2) @(negedge clk_i);
        check("t5_busy_before", 64'(bus.busy_o), 64'd1);
        #2 rst_n_i = 1'b0;
        #1 check("t5_async_outs", all_outs(), 64'd0);
        drive(0, 1'b0, 1'b0, 4'd0, 8'd0);
        repeat (2) @(negedge clk_i);
        check("t5_held_outs", all_outs(), 64'd0);
        rst_n_i = 1'b1;
        mem_en  = 1'b1;
        @(negedge clk_i);
        drive(0, 1'b1, 1'b0, 4'd3, 8'd0);
        drive(1, 1'b1, 1'b0, 4'd2, 8'd0);
        wait_ready(0, 40, lat, mv_at, mv_cnt);
        check("t5_r0_lat", 64'(lat), 64'd3);
        check("t5_r0_rdata", 64'(bus.r0_rdata_o), 64'hA5);
        drive(0, 1'b0, 1'b0, 4'd3, 8'd0);
        wait_ready(1, 40, lat, mv_at, mv_cnt);
        check("t5_r1_lat", 64'(lat), 64'd4);
        check("t5_r1_rdata", 64'(bus.r1_rdata_o), 64'h33);
        drive(1, 1'b0, 1'b0, 4'd2, 8'd0);
        @(negedge clk_i);

        // command latched at grant; later input changes ignored
        drive(0, 1'b1, 1'b1, 4'd15, 8'hFF);
        @(negedge clk_i);
        check("t6_issue", {48'd0, bus.mem_valid_o, bus.mem_wr_rd_o, 2'd0, bus.mem_addr_o,
                           bus.mem_wdata_o}, 64'h0000_0000_0000_C0FF | 64'h0F00);
        drive(0, 1'b1, 1'b1, 4'd7, 8'h00);
        wait_ready(0, 40, lat, mv_at, mv_cnt);
        check("t6_lat", 64'(lat), 64'd2);
        check("t6_err", 64'(bus.r0_err_o), 64'd0);
        check("t6_rdata_kept", 64'(bus.r0_rdata_o), 64'hA5);
        drive(0, 1'b0, 1'b1, 4'd7, 8'h00);
        @(negedge clk_i);
        check("t6_addr7_untouched", 64'(mem[7]), 64'd0);
        xfer("t6r", 0, 1'b0, 4'd15, 8'd0, 8'hFF, 3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
